// File: rtl/mext_issue_ctrl.sv
// mext_issue_ctrl
// Execute-stage initiator for the RV32M iterative multiplier and divider.
// It accepts an M-extension instruction, latches the operands, fires a
// one-cycle start pulse at the selected unit and stalls the pipeline until
// that unit reports ready. It then presents the 32-bit architectural result
// to the ALU result mux for one cycle.
//
// Optional feature macro: MEXT_DIV_SHORTCUT_EN
//   When defined, RISC-V divide special cases (divide by zero and signed
//   overflow) are answered locally without starting the divider.
//   When undefined, every divide op goes through the divider.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   startE              M-extension instruction valid in Execute
//   funct3E             operation select (MUL..REMU)
//   SrcAE, SrcBE        rs1 / rs2 operands after forwarding
//   operand1, operand2  latched operands to both units
//   mul_start           one-cycle start pulse to the multiplier
//   mul_opcode          funct3[1:0] for the multiplier
//   mul_ready           multiplier done, result_multiply valid
//   result_multiply     64-bit product
//   div_start           one-cycle start pulse to the divider
//   div_opcode          funct3[1:0] for the divider
//   div_ready           divider done, result_divide valid
//   result_divide       quotient or remainder
//   mul_use             stall request to PC, IF/ID and ID/EX
//   flagM               result_m valid this cycle
//   result_m            architectural result
module mext_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic        mul_start,
  output logic [1:0]  mul_opcode,
  input  logic        mul_ready,
  input  logic [63:0] result_multiply,
  output logic        div_start,
  output logic [1:0]  div_opcode,
  input  logic        div_ready,
  input  logic [31:0] result_divide,
  output logic        mul_use,
  output logic        flagM,
  output logic [31:0] result_m
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] res_q, res_d;

  logic        sc_hit;
  logic [31:0] sc_val;

`ifdef MEXT_DIV_SHORTCUT_EN
  // Returns {hit, value}. Only divide ops (f3[2]=1) qualify.
  // Divide by zero: quotient all ones, remainder is the dividend.
  // Signed overflow (DIV/REM, most negative / -1): quotient is the
  // dividend, remainder zero.
  function automatic logic [32:0] div_special(input logic [2:0]         f3,
                                              input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic [32:0] r;
    r = '0;
    if (f3[2]) begin
      if (b == 32'sd0) begin
        r = {1'b1, (f3[1] ? a : 32'hFFFF_FFFF)};
      end else if (!f3[0] && (a == 32'sh8000_0000) && (b == -32'sd1)) begin
        r = {1'b1, (f3[1] ? 32'h0000_0000 : 32'h8000_0000)};
      end
    end
    return r;
  endfunction

  assign {sc_hit, sc_val} = div_special(funct3E, SrcAE, SrcBE);
`else
  assign sc_hit = 1'b0;
  assign sc_val = '0;
`endif

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    f3_d      = f3_q;
    res_d     = res_q;
    mul_start = 1'b0;
    div_start = 1'b0;
    mul_use   = 1'b0;
    flagM     = 1'b0;
    result_m  = '0;
    case (state_q)
      IDLE: begin
        if (startE) begin
          op1_d = SrcAE;
          op2_d = SrcBE;
          f3_d  = funct3E;
          if (sc_hit) begin
            // Result is known now; no stall so the pipeline consumes it next cycle.
            res_d   = sc_val;
            state_d = DONE;
          end else begin
            mul_use = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mul_use   = 1'b1;
        mul_start = ~f3_q[2];
        div_start = f3_q[2];
        state_d   = BUSY;
      end
      BUSY: begin
        mul_use = 1'b1;
        // Only the selected unit's ready is honoured.
        if (f3_q[2] ? div_ready : mul_ready) begin
          if (f3_q[2]) begin
            res_d = result_divide;
          end else if (f3_q[1:0] == 2'b00) begin
            res_d = result_multiply[31:0];
          end else begin
            res_d = result_multiply[63:32];
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // startE is still high for this same instruction; it is not re-accepted.
        flagM    = 1'b1;
        result_m = res_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign operand1   = op1_q;
  assign operand2   = op2_q;
  assign mul_opcode = f3_q[1:0];
  assign div_opcode = f3_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      f3_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      f3_q    <= f3_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mext_issue_ctrl.sv
// Testbench for mext_issue_ctrl: directed operations with behavioural
// multiplier/divider models, expected results queued by the stimulus and
// checked by an independent monitor whenever flagM is asserted.
module tb_mext_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic [31:0] operand1, operand2;
  logic        mul_start, div_start;
  logic [1:0]  mul_opcode, div_opcode;
  logic        mul_ready = 1'b0;
  logic        div_ready = 1'b0;
  logic [63:0] result_multiply = '0;
  logic [31:0] result_divide = '0;
  logic        mul_use, flagM;
  logic [31:0] result_m;

  int checks = 0;
  int errors = 0;
  int flag_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  logic [63:0] mul_val = '0;
  logic [31:0] div_val = '0;
  int mul_lat = 4, div_lat = 4;
  int mul_cnt = 0, div_cnt = 0;

`ifdef MEXT_DIV_SHORTCUT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  mext_issue_ctrl dut (
    .clk(clk), .rst(rst), .startE(startE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .operand1(operand1), .operand2(operand2),
    .mul_start(mul_start), .mul_opcode(mul_opcode), .mul_ready(mul_ready),
    .result_multiply(result_multiply), .div_start(div_start),
    .div_opcode(div_opcode), .div_ready(div_ready),
    .result_divide(result_divide), .mul_use(mul_use), .flagM(flagM),
    .result_m(result_m)
  );

  always #5 clk = ~clk;

  // Unit models: ready (with result) 'lat' cycles after the start pulse.
  always @(negedge clk) begin
    mul_ready = 1'b0;
    result_multiply = '0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        mul_ready = 1'b1;
        result_multiply = mul_val;
      end
    end
    if (mul_start === 1'b1) mul_cnt = mul_lat;
    div_ready = 1'b0;
    result_divide = '0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_ready = 1'b1;
        result_divide = div_val;
      end
    end
    if (div_start === 1'b1) div_cnt = div_lat;
  end

  // Monitor: every flagM cycle consumes one expected result.
  always @(negedge clk) begin
    if (flagM === 1'b1) begin
      flag_total++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_m unexpected flagM got %h want none", result_m);
      end else begin
        mon_exp = exp_q.pop_front();
        if (result_m !== mon_exp) begin
          errors++;
          $display("FAIL result_m got %h want %h", result_m, mon_exp);
        end
      end
    end
  end

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endfunction

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] ures,
                        input logic [31:0] expv, input bit sc, input int lat,
                        input bit hold);
    int k, done_k, ms, ds, use_bad;
    @(negedge clk);
    mul_val = ures; div_val = ures[31:0]; mul_lat = lat; div_lat = lat;
    funct3E = f3; SrcAE = a; SrcBE = b; startE = 1'b1;
    exp_q.push_back(expv);
    #1 chk({nm, " mul_use_accept"}, mul_use, !sc);
    done_k = 0; ms = 0; ds = 0; use_bad = 0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (mul_start === 1'b1) ms++;
      if (div_start === 1'b1) ds++;
      if (k == 1) begin
        chk({nm, " operands"}, {operand1, operand2}, {a, b});
        chk({nm, " opcode"}, f3[2] ? div_opcode : mul_opcode, f3[1:0]);
      end
      if (flagM === 1'b1) begin
        done_k = k;
        chk({nm, " mul_use_done"}, mul_use, 1'b0);
        break;
      end
      if (mul_use !== 1'b1) use_bad++;
      startE = 1'b0;
    end
    startE = hold;
    chk({nm, " done_cycle"}, done_k, sc ? 1 : 2 + lat);
    chk({nm, " mul_start_cnt"}, ms, (!sc && !f3[2]) ? 1 : 0);
    chk({nm, " div_start_cnt"}, ds, (!sc && f3[2]) ? 1 : 0);
    chk({nm, " mul_use_stall"}, use_bad, 0);
  endtask

  initial begin
    int f0, ms;
    rst = 1'b1; startE = 1'b0; funct3E = '0; SrcAE = '0; SrcBE = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {mul_start, div_start, mul_use, flagM, mul_opcode, div_opcode}, '0);
    chk("rst_data", {operand1, operand2}, '0);
    chk("rst_result", result_m, '0);
    rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 32'hFFFF_FFEB, 1'b0, 4, 1'b0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE, 1'b0, 2, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,        64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 3, 1'b0);
    run_op("divu",   3'b101, 32'd100,      32'd7,        64'd14,                 32'd14,        1'b0, 3, 1'b0);
    run_op("div0",   3'b100, 32'h0000_1234, 32'd0,        64'hFFFF_FFFF,          32'hFFFF_FFFF, SC,   5, 1'b0);
    run_op("remu0",  3'b111, 32'd5,        32'd0,        64'd5,                  32'd5,         SC,   5, 1'b0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000,         32'h8000_0000, SC,   4, 1'b0);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,                 32'd0,         SC,   4, 1'b0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF,          32'hFFFF_FFFF, 1'b0, 2, 1'b0);

    // Reset while BUSY; the multiplier's later ready must be ignored.
    @(negedge clk);
    mul_val = 64'h1111_2222_3333_4444; mul_lat = 8;
    funct3E = 3'b011; SrcAE = 32'hA5A5_A5A5; SrcBE = 32'h5A5A_5A5A; startE = 1'b1;
    @(negedge clk); startE = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_ctrl", {mul_start, div_start, mul_use, flagM, mul_opcode, div_opcode}, '0);
    chk("midrst_data", {operand1, operand2}, '0);
    chk("midrst_result", result_m, '0);
    f0 = flag_total; ms = 0;
    repeat (15) begin
      @(negedge clk);
      if (mul_start === 1'b1) ms++;
    end
    chk("midrst_no_flag", flag_total - f0, 0);
    chk("midrst_no_start", ms, 0);

    // Back-to-back multiplies with startE held high through DONE.
    f0 = flag_total;
    run_op("b2b_mul",  3'b000, 32'd5,         32'd6, 64'd30,                  32'd30, 1'b0, 3, 1'b1);
    run_op("b2b_mulh", 3'b001, 32'h4000_0000, 32'd8, 64'h0000_0002_0000_0000, 32'd2,  1'b0, 3, 1'b0);
    ms = 0;
    repeat (6) begin
      @(negedge clk);
      if (mul_start === 1'b1) ms++;
    end
    chk("b2b_flag_count", flag_total - f0, 2);
    chk("b2b_no_extra_start", ms, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mext_issue_ctrl.md
# mext_issue_ctrl

Execute-stage initiator for the RV32M iterative arithmetic units. It accepts an M-extension instruction from the Execute stage, latches its operands, starts the multiplier or divider with a one-cycle pulse, and stalls the pipeline while the unit runs. When the unit reports ready, it returns the 32-bit architectural result to the ALU result mux. RISC-V divide special cases are resolved locally without starting the divider.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- startE  in  1  M-extension instruction valid in Execute
- funct3E  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE / SrcBE  in  32  rs1 / rs2 operands (post-forwarding)
- operand1 / operand2  out  32  latched operands to both units
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_opcode  out  2  funct3E[1:0] for multiply ops
- mul_ready  in  1  multiplier done; result_multiply valid this cycle
- result_multiply  in  64  multiplier product
- div_start  out  1  one-cycle start pulse to the divider
- div_opcode  out  2  funct3E[1:0] for divide ops
- div_ready  in  1  divider done; result_divide valid this cycle
- result_divide  in  32  quotient or remainder
- mul_use  out  1  stall request to PC, IF/ID and ID/EX
- flagM  out  1  result_m valid; ALU selects result_m
- result_m  out  32  architectural result

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE, startE=1:
  - latch SrcAE, SrcBE and funct3E;
  - shortcut case: go to DONE with the precomputed result;
  - otherwise go to ISSUE.
- ISSUE:
  - pulse mul_start if funct3[2]=0, else div_start;
  - go to BUSY.
- BUSY:
  - hold until the selected unit's ready is 1;
  - capture the result: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32]; divide ops give result_divide;
  - go to DONE.
- DONE:
  - flagM=1 and result_m = captured value for exactly one cycle, then IDLE;
  - startE is ignored in DONE, because the same instruction is still in Execute.
- mul_use = (IDLE & startE & no-shortcut) | ISSUE | BUSY. It is combinational from startE, so the instruction cannot leave Execute in its first cycle.
- Shortcut cases (under MEXT_DIV_SHORTCUT_EN):
  - divisor 0: DIV and DIVU give 0xFFFFFFFF; REM and REMU give the dividend;
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
- A ready from the non-selected unit, or any ready outside BUSY, is ignored.
- operand1, operand2, mul_opcode and div_opcode hold their values from latch until the next accept.

## Timing
- Reset values: state=IDLE. mul_start, div_start, mul_use and flagM are 0. result_m, operand1, operand2 and both opcodes are 0.
- Reset mid-operation returns to IDLE next cycle with all outputs at reset values. A unit ready arriving later is ignored.
- Accept in cycle T: ISSUE in T+1 (start pulse), BUSY from T+2.
- Ready seen in cycle R gives DONE in R+1. mul_use falls in R+1.
- Shortcut accept in T gives DONE in T+1. mul_use stays 0, so the pipeline advances and the result is consumed in T+1.
- Back-to-back M instructions: the second is accepted the cycle after DONE.

## Configuration
- MEXT_DIV_SHORTCUT_EN defined: special-case detection and local results as above. The divider is never started for those cases.
- Not defined: all divide ops go through ISSUE and BUSY, and the divider's own special-case result is returned. In this mode mul_use is 1 in the accept cycle for every op.

## Test plan
- MUL, SrcAE=7, SrcBE=0xFFFFFFFD, multiplier ready 4 cycles after start -> one mul_start pulse at T+1, mul_use high T..T+5, flagM at T+6 with result_m=0xFFFFFFEB.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF -> result_m=0xFFFFFFFE.
- DIV with divisor 0, shortcut enabled -> no div_start, flagM at T+1, result_m=0xFFFFFFFF. REMU 5/0 -> result_m=5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with same operands -> 0.
- rst asserted in BUSY, then mul_ready pulsed -> outputs at reset values, no flagM.
- Two consecutive MULs, with startE held high through DONE -> exactly two mul_start pulses and two flagM pulses.
